// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
//   Bundles the CPU port, the video fetch port and the memory-side signals
//   of the two-requester memory front end.
//
//   CPU port   : cpu_req/cpu_wr/cpu_wide/cpu_addr/cpu_wdata in,
//                cpu_ack/cpu_rvalid/cpu_rdata out
//   Video port : vid_req/vid_addr in, vid_ack/vid_rvalid/vid_rdata out
//   Memory     : mem_en/mem_wr/mem_wide/mem_addr/mem_din out, mem_dout in
//
//   slave  : the arbiter's view.
//   master : the environment's view (requesters plus the memory block).
// ---------------------------------------------------------------------------
interface mem_arbiter_if;
  // CPU requester
  logic        cpu_req;
  logic        cpu_wr;
  logic        cpu_wide;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_ack;
  logic        cpu_rvalid;
  logic [15:0] cpu_rdata;

  // Video fetch requester (word reads only)
  logic        vid_req;
  logic [15:0] vid_addr;
  logic        vid_ack;
  logic        vid_rvalid;
  logic [15:0] vid_rdata;

  // Memory block
  logic        mem_en;
  logic        mem_wr;
  logic        mem_wide;
  logic [15:0] mem_addr;
  logic [15:0] mem_din;
  logic [15:0] mem_dout;

  modport slave (
    input  cpu_req, cpu_wr, cpu_wide, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rvalid, cpu_rdata,
    input  vid_req, vid_addr,
    output vid_ack, vid_rvalid, vid_rdata,
    output mem_en, mem_wr, mem_wide, mem_addr, mem_din,
    input  mem_dout
  );

  modport master (
    output cpu_req, cpu_wr, cpu_wide, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rvalid, cpu_rdata,
    output vid_req, vid_addr,
    input  vid_ack, vid_rvalid, vid_rdata,
    input  mem_en, mem_wr, mem_wide, mem_addr, mem_din,
    output mem_dout
  );
endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Two-requester front end for the 16-bit byte-addressable memory block.
//   Video fetch has priority; a saturating wait counter forces a CPU request
//   through after CPU_MAX_WAIT consecutive denied cycles. Read data comes
//   back from memory one cycle after the access and is steered to the port
//   that issued it, using a one-deep registered tag.
//
//   Ports:
//     clk   : system clock, all state on the rising edge
//     reset : synchronous, active-high
//     bus   : mem_arbiter_if.slave (CPU port, video port, memory side)
//
//   Parameters:
//     CPU_MAX_WAIT : denied cycles before a CPU request is forced (1..15)
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int CPU_MAX_WAIT = 4
) (
  input  logic clk,
  input  logic reset,
  mem_arbiter_if.slave bus
);

  localparam logic [3:0] MaxWait = 4'(CPU_MAX_WAIT);

  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [1:0]  rd_tag_q, rd_tag_d;       // {cpu read, video read} in flight
  logic [15:0] cpu_hold_q, cpu_hold_d;
  logic [15:0] vid_hold_q, vid_hold_d;

  logic force_cpu;
  logic cpu_gnt;
  logic vid_gnt;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    if (v >= MaxWait) return MaxWait;
    return v + 4'd1;
  endfunction

  // Grant: forced CPU first, then video, then CPU. Nothing is granted while
  // reset is high so a request presented during reset is never accepted.
  always_comb begin
    force_cpu = bus.cpu_req && (wait_cnt_q == MaxWait);
    cpu_gnt   = 1'b0;
    vid_gnt   = 1'b0;
    if (!reset) begin
      if (force_cpu)        cpu_gnt = 1'b1;
      else if (bus.vid_req) vid_gnt = 1'b1;
      else if (bus.cpu_req) cpu_gnt = 1'b1;
    end
  end

  assign bus.cpu_ack = cpu_gnt;
  assign bus.vid_ack = vid_gnt;

  // Memory drive follows the grant directly.
  always_comb begin
    bus.mem_en   = 1'b0;
    bus.mem_wr   = 1'b0;
    bus.mem_wide = 1'b0;
    bus.mem_addr = 16'h0000;
    bus.mem_din  = 16'h0000;
    if (cpu_gnt) begin
      bus.mem_en   = 1'b1;
      bus.mem_wr   = bus.cpu_wr;
      bus.mem_wide = bus.cpu_wide;
      bus.mem_addr = bus.cpu_addr;
      bus.mem_din  = bus.cpu_wdata;
    end else if (vid_gnt) begin
      bus.mem_en   = 1'b1;
      bus.mem_wide = 1'b1;
      bus.mem_addr = bus.vid_addr;
    end
  end

  // Next-state: wait counter runs only while the CPU is asking and losing.
  always_comb begin
    wait_cnt_d = 4'd0;
    if (bus.cpu_req && !cpu_gnt) wait_cnt_d = sat_inc(wait_cnt_q);

    rd_tag_d = {cpu_gnt && !bus.cpu_wr, vid_gnt};

    cpu_hold_d = cpu_hold_q;
    vid_hold_d = vid_hold_q;
    if (rd_tag_q[1]) cpu_hold_d = bus.mem_dout;
    if (rd_tag_q[0]) vid_hold_d = bus.mem_dout;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= 4'd0;
      rd_tag_q   <= 2'b00;
      cpu_hold_q <= 16'h0000;
      vid_hold_q <= 16'h0000;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      rd_tag_q   <= rd_tag_d;
      cpu_hold_q <= cpu_hold_d;
      vid_hold_q <= vid_hold_d;
    end
  end

  // Return path: live memory data on the valid cycle, held value otherwise.
  // Outputs are forced low during reset so a read in flight when reset
  // arrives is dropped.
  always_comb begin
    bus.cpu_rvalid = rd_tag_q[1] && !reset;
    bus.vid_rvalid = rd_tag_q[0] && !reset;
    bus.cpu_rdata  = 16'h0000;
    bus.vid_rdata  = 16'h0000;
    if (!reset) begin
      bus.cpu_rdata = rd_tag_q[1] ? bus.mem_dout : cpu_hold_q;
      bus.vid_rdata = rd_tag_q[0] ? bus.mem_dout : vid_hold_q;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic clk;
  logic reset;
  logic clr;

  mem_arbiter_if bus ();

  mem_arbiter #(.CPU_MAX_WAIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory block model: big-endian words (addr holds the high byte), byte
  // reads return the byte in the low half, one-cycle read latency.
  logic [7:0] mem [0:1023];
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
    end else if (bus.mem_en) begin
      if (bus.mem_wr) begin
        if (bus.mem_wide) begin
          mem[bus.mem_addr[9:0]]          <= bus.mem_din[15:8];
          mem[bus.mem_addr[9:0] + 10'd1]  <= bus.mem_din[7:0];
        end else begin
          mem[bus.mem_addr[9:0]]          <= bus.mem_din[7:0];
        end
      end else begin
        if (bus.mem_wide)
          bus.mem_dout <= {mem[bus.mem_addr[9:0]], mem[bus.mem_addr[9:0] + 10'd1]};
        else
          bus.mem_dout <= {8'h00, mem[bus.mem_addr[9:0]]};
      end
    end
  end

  // Reference model and scoreboard
  logic [7:0]  ref_mem [0:1023];
  logic [15:0] cpu_q[$];
  logic [15:0] vid_q[$];
  logic [15:0] last_cpu, last_vid;
  logic        exp_cv, exp_vv;
  logic        ca, va;
  int          n_pass, n_total;

  function automatic logic [15:0] ref_read(input logic [15:0] a, input logic wide);
    if (wide) return {ref_mem[a[9:0]], ref_mem[a[9:0] + 10'd1]};
    return {8'h00, ref_mem[a[9:0]]};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Mid-cycle: sample acks, update the reference, push expected returns.
  task automatic pre();
    #1;
    ca = bus.cpu_ack;
    va = bus.vid_ack;
    chk("ack_exclusive", {15'd0, ca && va}, 16'h0000);
    exp_cv = 1'b0;
    exp_vv = 1'b0;
    if (!reset && ca) begin
      if (bus.cpu_wr) begin
        if (bus.cpu_wide) begin
          ref_mem[bus.cpu_addr[9:0]]         = bus.cpu_wdata[15:8];
          ref_mem[bus.cpu_addr[9:0] + 10'd1] = bus.cpu_wdata[7:0];
        end else begin
          ref_mem[bus.cpu_addr[9:0]]         = bus.cpu_wdata[7:0];
        end
      end else begin
        cpu_q.push_back(ref_read(bus.cpu_addr, bus.cpu_wide));
        exp_cv = 1'b1;
      end
    end
    if (!reset && va) begin
      vid_q.push_back(ref_read(bus.vid_addr, 1'b1));
      exp_vv = 1'b1;
    end
  endtask

  // After the edge: compare returns against the scoreboard.
  task automatic post();
    logic rst_edge;
    logic [15:0] e;
    @(posedge clk);
    rst_edge = reset;
    #1;
    if (rst_edge) begin
      last_cpu = 16'h0000;
      last_vid = 16'h0000;
      cpu_q.delete();
      vid_q.delete();
      exp_cv = 1'b0;
      exp_vv = 1'b0;
    end
    chk("cpu_rvalid", {15'd0, bus.cpu_rvalid}, {15'd0, exp_cv});
    chk("vid_rvalid", {15'd0, bus.vid_rvalid}, {15'd0, exp_vv});
    if (bus.cpu_rvalid && cpu_q.size() > 0) begin
      e = cpu_q.pop_front();
      chk("cpu_rdata", bus.cpu_rdata, e);
      last_cpu = e;
    end else if (!bus.cpu_rvalid) begin
      chk("cpu_rdata_hold", bus.cpu_rdata, last_cpu);
    end
    if (bus.vid_rvalid && vid_q.size() > 0) begin
      e = vid_q.pop_front();
      chk("vid_rdata", bus.vid_rdata, e);
      last_vid = e;
    end else if (!bus.vid_rvalid) begin
      chk("vid_rdata_hold", bus.vid_rdata, last_vid);
    end
  endtask

  task automatic chk_all_zero();
    chk("rst_cpu_ack",    {15'd0, bus.cpu_ack},    16'h0);
    chk("rst_vid_ack",    {15'd0, bus.vid_ack},    16'h0);
    chk("rst_mem_en",     {15'd0, bus.mem_en},     16'h0);
    chk("rst_mem_wr",     {15'd0, bus.mem_wr},     16'h0);
    chk("rst_mem_addr",   bus.mem_addr,            16'h0);
    chk("rst_mem_din",    bus.mem_din,             16'h0);
    chk("rst_cpu_rvalid", {15'd0, bus.cpu_rvalid}, 16'h0);
    chk("rst_cpu_rdata",  bus.cpu_rdata,           16'h0);
    chk("rst_vid_rvalid", {15'd0, bus.vid_rvalid}, 16'h0);
    chk("rst_vid_rdata",  bus.vid_rdata,           16'h0);
  endtask

  task automatic cpu_set(input logic req, input logic wr, input logic wide,
                         input logic [15:0] addr, input logic [15:0] wdata);
    bus.cpu_req   = req;
    bus.cpu_wr    = wr;
    bus.cpu_wide  = wide;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
  endtask

  task automatic vid_set(input logic req, input logic [15:0] addr);
    bus.vid_req  = req;
    bus.vid_addr = addr;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    last_cpu = 16'h0000;
    last_vid = 16'h0000;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;

    // Reset held two cycles with both requesters asking.
    reset = 1'b1;
    clr   = 1'b1;
    cpu_set(1'b1, 1'b0, 1'b1, 16'h0010, 16'h0000);
    vid_set(1'b1, 16'h0020);
    for (int i = 0; i < 2; i++) begin
      pre();
      chk_all_zero();
      post();
      clr = 1'b0;
    end

    // First cycle after release: video wins.
    reset = 1'b0;
    pre();
    chk("rel_vid_ack",  {15'd0, va}, 16'h1);
    chk("rel_cpu_ack",  {15'd0, ca}, 16'h0);
    chk("rel_mem_addr", bus.mem_addr, 16'h0020);
    chk("rel_mem_wide", {15'd0, bus.mem_wide}, 16'h1);
    post();
    vid_set(1'b0, 16'h0000);
    pre();
    chk("rel_cpu_ack2", {15'd0, ca}, 16'h1);
    post();
    cpu_set(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    pre(); post();

    // CPU byte write, then wide and byte reads of the surrounding word.
    cpu_set(1'b1, 1'b1, 1'b0, 16'h0101, 16'h00AB);
    pre();
    chk("bw_cpu_ack",  {15'd0, ca}, 16'h1);
    chk("bw_mem_en",   {15'd0, bus.mem_en}, 16'h1);
    chk("bw_mem_wr",   {15'd0, bus.mem_wr}, 16'h1);
    chk("bw_mem_wide", {15'd0, bus.mem_wide}, 16'h0);
    chk("bw_mem_addr", bus.mem_addr, 16'h0101);
    chk("bw_mem_din",  bus.mem_din, 16'h00AB);
    post();
    cpu_set(1'b1, 1'b0, 1'b1, 16'h0100, 16'h0000);
    pre(); post();
    chk("bw_word_rd",  bus.cpu_rdata, 16'h00AB);
    cpu_set(1'b1, 1'b0, 1'b0, 16'h0101, 16'h0000);
    pre();
    chk("br_mem_wide", {15'd0, bus.mem_wide}, 16'h0);
    post();
    chk("br_byte_rd",  bus.cpu_rdata, 16'h00AB);

    // Wide write then read back; value must hold for five idle cycles.
    cpu_set(1'b1, 1'b1, 1'b1, 16'h0200, 16'h1234);
    pre(); post();
    cpu_set(1'b1, 1'b0, 1'b1, 16'h0200, 16'h0000);
    pre(); post();
    chk("ww_rd", bus.cpu_rdata, 16'h1234);
    cpu_set(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      pre(); post();
    end
    chk("ww_hold5", bus.cpu_rdata, 16'h1234);

    // Contention: video always asking, CPU forced through every fifth cycle.
    vid_set(1'b1, 16'h0200);
    cpu_set(1'b1, 1'b0, 1'b1, 16'h0100, 16'h0000);
    for (int i = 0; i < 10; i++) begin
      pre();
      chk("ct_cpu_ack", {15'd0, ca}, {15'd0, (i % 5) == 4});
      chk("ct_vid_ack", {15'd0, va}, {15'd0, (i % 5) != 4});
      post();
    end
    vid_set(1'b0, 16'h0000);
    cpu_set(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    pre(); post();

    // Preload three words, then alternating back-to-back reads.
    cpu_set(1'b1, 1'b1, 1'b1, 16'h0000, 16'h1111);
    pre(); post();
    cpu_set(1'b1, 1'b1, 1'b1, 16'h0002, 16'h2222);
    pre(); post();
    cpu_set(1'b1, 1'b1, 1'b1, 16'h0004, 16'h3333);
    pre(); post();
    cpu_set(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    vid_set(1'b1, 16'h0000);
    pre(); chk("alt_vid_ack0", {15'd0, va}, 16'h1); post();
    vid_set(1'b0, 16'h0000);
    cpu_set(1'b1, 1'b0, 1'b1, 16'h0002, 16'h0000);
    pre(); chk("alt_cpu_ack", {15'd0, ca}, 16'h1); post();
    chk("alt_vid_word0", bus.vid_rdata, 16'h1111);
    cpu_set(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    vid_set(1'b1, 16'h0004);
    pre(); chk("alt_vid_ack4", {15'd0, va}, 16'h1); post();
    chk("alt_cpu_word2", bus.cpu_rdata, 16'h2222);
    vid_set(1'b0, 16'h0000);
    pre(); post();
    chk("alt_vid_word4", bus.vid_rdata, 16'h3333);
    chk("alt_cpu_kept",  bus.cpu_rdata, 16'h2222);

    // Reset arrives while a CPU read is in flight and another is requested.
    cpu_set(1'b1, 1'b0, 1'b1, 16'h0200, 16'h0000);
    pre(); post();
    reset = 1'b1;
    pre();
    chk_all_zero();
    post();
    reset = 1'b0;
    cpu_set(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    pre();
    chk("postrst_cpu_rvalid", {15'd0, bus.cpu_rvalid}, 16'h0);
    chk("postrst_cpu_rdata",  bus.cpu_rdata, 16'h0000);
    chk("postrst_vid_rdata",  bus.vid_rdata, 16'h0000);
    post();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester front end for the 16-bit byte-addressable memory block. Directly upstream of it; drives its en/wr/wide/addr/din and consumes its dout.
- Arbitrates between the CPU port (read/write, byte or word) and the video fetch port (word reads only).
- Video has priority. A wait counter guarantees CPU forward progress.
- Routes the one-cycle-latency read data back to the requester that issued the read.

Parameters:
- CPU_MAX_WAIT, 4: consecutive cycles a CPU request may be denied before it is forced through. Legal range 1..15.

Ports:
- clk  in  1  system clock; all state on rising edge
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU request valid; held with its fields until cpu_ack
- cpu_wr  in  1  1 = write, 0 = read
- cpu_wide  in  1  1 = 16-bit access, 0 = 8-bit access
- cpu_addr  in  16  byte address; unaligned wide access allowed
- cpu_wdata  in  16  write data
- cpu_ack  out  1  request accepted this cycle (combinational)
- cpu_rvalid  out  1  read data valid (cycle after accepted read)
- cpu_rdata  out  16  read data; holds last CPU read value when cpu_rvalid=0
- vid_req  in  1  video word-read request; held until vid_ack
- vid_addr  in  16  byte address
- vid_ack  out  1  request accepted this cycle (combinational)
- vid_rvalid  out  1  read data valid
- vid_rdata  out  16  read data; holds last video read value when vid_rvalid=0
- mem_en  out  1  to memory en
- mem_wr  out  1  to memory wr
- mem_wide  out  1  to memory wide
- mem_addr  out  16  to memory addr
- mem_din  out  16  to memory din
- mem_dout  in  16  from memory; valid the cycle after a read with mem_en=1

Behaviour:
- Transfer occurs on a rising edge where req=1 and ack=1. Ack is combinational from req and the registered state, so a transfer costs one cycle.
- Grant rules, evaluated each cycle, first match wins:
  - force = cpu_req && wait_cnt == CPU_MAX_WAIT: CPU granted.
  - vid_req: video granted.
  - cpu_req: CPU granted.
  - Otherwise idle.
- At most one ack per cycle; the two acks are never high together.
- Memory drive on CPU grant:
  - mem_en=1, mem_wr=cpu_wr, mem_wide=cpu_wide, mem_addr=cpu_addr, mem_din=cpu_wdata.
- Memory drive on video grant:
  - mem_en=1, mem_wr=0, mem_wide=1, mem_addr=vid_addr, mem_din=0.
- Memory drive when idle: all mem_* = 0.
- wait_cnt (4-bit register):
  - Reset 0.
  - cpu_req && !cpu_ack: increment, saturating at CPU_MAX_WAIT.
  - Otherwise: 0.
- Read return tag, registered: rd_tag[1:0] = {cpu read accepted, video read accepted}, captured each edge.
- The cycle after an accepted read:
  - The matching rvalid=1.
  - The matching rdata = mem_dout (pass-through).
  - mem_dout is captured into that port's hold register at the same edge.
- When rvalid=0, rdata = hold register.
- CPU writes produce no rvalid.
- Back-to-back reads from either or both ports are sustained at one per cycle. The tag pipeline is one deep and no stall exists.
- Reset behaviour:
  - All outputs 0; rd_tag, wait_cnt and both hold registers 0.
  - A read accepted in the cycle reset asserts yields no rvalid.
  - Requesters must re-present after reset deasserts.

Test Plan:
- Reset held 2 cycles with cpu_req=vid_req=1 -> all outputs 0 throughout. First cycle after release: vid_ack=1, mem_addr=vid_addr.
- CPU byte write cpu_addr=0x0101, cpu_wdata=0x00AB, wide=0, idle video -> cpu_ack same cycle; mem_en=1, mem_wr=1, mem_wide=0. Next cycle cpu_rvalid=0. A following wide read of 0x0100 returns 0x??AB in low byte order per memory map.
- Wide CPU write 0x1234 to 0x0200, then CPU read 0x0200 -> cpu_rvalid one cycle after ack with cpu_rdata=0x1234. cpu_rdata still 0x1234 five cycles later.
- vid_req continuously high plus cpu_req from cycle 0, CPU_MAX_WAIT=4 -> vid_ack cycles 0-3, cpu_ack cycle 4, vid_ack resumes cycle 5. Pattern repeats every 5 cycles.
- Alternating accepted reads vid 0x0000, cpu 0x0002, vid 0x0004 on consecutive cycles -> vid_rvalid, cpu_rvalid, vid_rvalid on the following three cycles, each with the correct word and no cross-routing.
- Reset asserted the cycle a CPU read is acked -> cpu_rvalid stays 0 and cpu_rdata=0 the next cycle.
